// File: rtl/port_read_flush_tracker.sv
// Tracks outstanding AFU reads and sequences the port read-flush:
// block new TX, drain in-flight reads, then report done or timeout.
module port_read_flush_tracker #(
  parameter int CNT_WIDTH      = 10,
  parameter int TIMEOUT_CYCLES = 65536
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 i_flush_req,
  input  logic                 i_rd_req_vld,
  input  logic                 i_rd_cpl_vld,
  input  logic                 i_err_clr,
  output logic                 o_tx_block,
  output logic                 o_read_flush_done,
  output logic [CNT_WIDTH-1:0] o_outstanding,
  output logic                 o_timeout_err,
  output logic                 o_underflow_err
);

  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [TW-1:0] TMAX = TW'(TIMEOUT_CYCLES - 1);
  localparam logic [CNT_WIDTH-1:0] CMAX = {CNT_WIDTH{1'b1}};

  typedef enum logic [2:0] {
    IDLE,
    BLOCK,
    DRAIN,
    DONE,
    TMO
  } state_t;

  state_t          state;
  logic [TW-1:0]   timer;
  logic            blk;
  logic            inc;
  logic            dec;
  logic            uflow;
  logic            tmo_hit;

  assign inc   = i_rd_req_vld & ~i_rd_cpl_vld;
  assign dec   = i_rd_cpl_vld & ~i_rd_req_vld;
  assign uflow = dec & (o_outstanding == '0);

  // Count-zero beats timeout in the same drain cycle.
  assign tmo_hit = (state == DRAIN) & i_flush_req &
                   (o_outstanding != '0) & (timer == TMAX);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state             <= IDLE;
      timer             <= '0;
      blk               <= 1'b0;
      o_tx_block        <= 1'b0;
      o_read_flush_done <= 1'b0;
      o_outstanding     <= '0;
      o_timeout_err     <= 1'b0;
      o_underflow_err   <= 1'b0;
    end else begin
      if (uflow)
        o_underflow_err <= 1'b1;
      else if (i_err_clr)
        o_underflow_err <= 1'b0;

      if (tmo_hit)
        o_timeout_err <= 1'b1;
      else if (i_err_clr)
        o_timeout_err <= 1'b0;

      if (inc && o_outstanding != CMAX)
        o_outstanding <= o_outstanding + 1'b1;
      else if (dec && o_outstanding != '0)
        o_outstanding <= o_outstanding - 1'b1;

      unique case (state)
        IDLE: begin
          if (i_flush_req) begin
            state      <= BLOCK;
            blk        <= 1'b0;
            o_tx_block <= 1'b1;
          end
        end
        BLOCK: begin
          if (!i_flush_req) begin
            state      <= IDLE;
            timer      <= '0;
            o_tx_block <= 1'b0;
          end else if (blk) begin
            state <= DRAIN;
            timer <= '0;
          end else begin
            blk <= 1'b1;
          end
        end
        DRAIN: begin
          if (!i_flush_req) begin
            state      <= IDLE;
            timer      <= '0;
            o_tx_block <= 1'b0;
          end else if (o_outstanding == '0) begin
            state             <= DONE;
            o_read_flush_done <= 1'b1;
          end else if (timer == TMAX) begin
            state             <= TMO;
            o_read_flush_done <= 1'b1;
          end else begin
            timer <= timer + 1'b1;
          end
        end
        DONE: begin
          if (!i_flush_req) begin
            state             <= IDLE;
            timer             <= '0;
            o_tx_block        <= 1'b0;
            o_read_flush_done <= 1'b0;
          end
        end
        TMO: begin
          // Lost reads are written off so the next flush starts clean.
          if (!i_flush_req) begin
            state             <= IDLE;
            timer             <= '0;
            o_tx_block        <= 1'b0;
            o_read_flush_done <= 1'b0;
            o_outstanding     <= '0;
          end
        end
        default: begin
          state             <= IDLE;
          o_tx_block        <= 1'b0;
          o_read_flush_done <= 1'b0;
        end
      endcase
    end
  end

endmodule
